gate_checker: RTL and testbench
===============================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter ERR_W, default 8: width of the error counter.
REQ-002 Parameter TIMEOUT_CYC, default 64: number of idle RUN cycles before the session is aborted.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a check session; sampled only in IDLE.
REQ-006 op  input  2  expected function, latched at start: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 s_valid  input  1  sample-stream valid.
REQ-008 s_a, s_b, s_y  input  1 each  DUT inputs and the DUT output under test.
REQ-009 s_ready  output  1  checker accepts a sample this cycle.
REQ-010 busy  output  1  session in progress.
REQ-011 done  output  1  single-cycle session-complete pulse.
REQ-012 pass  output  1  result of the last session; held until the next start.
REQ-013 err_cnt  output  ERR_W  mismatch count of the current or last session.
REQ-014 cov  output  4  coverage bitmap; bit {s_a,s_b} is set once that input pair has been checked.
REQ-015 timeout  output  1  the last session ended by timeout.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: s_ready=0 and busy=0; start=1 SHALL move to RUN and, on that edge, latch op and clear cov, err_cnt, timeout, pass and the idle counter.
REQ-018 RUN: s_ready=1 and busy=1; a sample is accepted when s_valid and s_ready are both 1.
REQ-019 For each accepted sample, the expected value SHALL be the latched op applied to s_a and s_b; on mismatch with s_y, err_cnt SHALL increment on the same edge.
REQ-020 err_cnt SHALL saturate at 2^ERR_W-1 and SHALL NOT wrap.
REQ-021 Each accepted sample SHALL set cov[{s_a,s_b}]; repeated pairs are still checked and counted.
REQ-022 On the edge where cov becomes 4'b1111 (including the acceptance that sets the last bit), the FSM SHALL go to DONE.
REQ-023 The idle counter SHALL increment on every RUN cycle with no acceptance and clear on any acceptance.
REQ-024 When the idle counter reaches TIMEOUT_CYC, the FSM SHALL set timeout=1 and go to DONE.
REQ-025 If completion and timeout occur on the same edge, completion SHALL win and timeout stays 0.
REQ-026 DONE: lasts exactly one cycle with done=1, busy=0 and s_ready=0; pass SHALL be registered as (err_cnt==0 && !timeout); the FSM then returns to IDLE.
REQ-027 start SHALL be ignored in RUN and DONE.
REQ-028 Outputs SHALL be driven directly from registers; done appears one cycle after the completing acceptance.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and set s_ready, busy, done, pass, timeout, err_cnt, cov and the idle counter to 0, mid-session included.
REQ-030 After rst deasserts, no session SHALL start until a new start pulse is seen in IDLE.

Configuration
REQ-031 With GATE_CHECKER_FAIL_CAPTURE_EN defined, the block SHALL add output fail_vec[2:0] = {s_a,s_b,s_y} of the first mismatching sample in the session. It SHALL add fail_vld[0:0], set at that capture. Both are cleared by start and by rst and stay frozen after the first capture.
REQ-032 Without GATE_CHECKER_FAIL_CAPTURE_EN, fail_vec and fail_vld SHALL NOT exist and the capture logic SHALL NOT be built.

Verification
REQ-033 op=00; stream (0,0,0) (0,1,0) (1,0,0) (1,1,1), one per cycle -> done pulses 1 cycle after the 4th acceptance; pass=1; err_cnt=0; cov=1111.
REQ-034 op=10; stream (0,0,0) (0,1,1) (1,0,1) (1,1,1) -> err_cnt=1; pass=0; with the macro defined, fail_vec=3'b111 and fail_vld=1.
REQ-035 op=01; 2 valid samples, then s_valid=0 for 64 cycles -> timeout=1; done pulses; pass=0; cov has 2 bits set.
REQ-036 ERR_W=2, op=11; 5 wrong samples on pair (0,0), then the 3 remaining pairs correct -> err_cnt=3 (saturated); pass=0.
REQ-037 rst=1 asynchronously mid-RUN after 2 samples -> all outputs 0 without waiting for a clock edge; a later start begins a clean session with err_cnt=0.
REQ-038 start held high through RUN and DONE -> op is not re-latched; a new session begins only on the first IDLE cycle.

Source files
------------

// File: rtl/gate_checker.sv
// Session-based checker for a 2-input logic gate: compares each sampled output against the latched function.
// Optional GATE_CHECKER_FAIL_CAPTURE_EN adds fail_vec/fail_vld capture of the first mismatching sample.
module gate_checker #(
  parameter int ERR_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             s_valid,
  input  logic             s_a,
  input  logic             s_b,
  input  logic             s_y,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             timeout
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic [2:0]       fail_vec,
  output logic [0:0]       fail_vld
`endif
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic              s_ready_next, busy_next, done_next, pass_next, timeout_next;
  logic [ERR_W-1:0]  err_next, err_inc;
  logic [3:0]        cov_next, cov_hit;
  logic              accept, expected, mismatch;

  always_comb begin
    case (op_reg)
      2'b00:   expected = s_a & s_b;
      2'b01:   expected = s_a | s_b;
      2'b10:   expected = s_a ^ s_b;
      default: expected = ~(s_a & s_b);
    endcase
  end

  assign accept   = (state_reg == RUN) && s_valid && s_ready;
  assign mismatch = accept && (expected != s_y);
  assign cov_hit  = 4'b0001 << {s_a, s_b};
  assign err_inc  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    idle_next    = idle_reg;
    s_ready_next = s_ready;
    busy_next    = busy;
    done_next    = 1'b0;
    pass_next    = pass;
    timeout_next = timeout;
    err_next     = err_cnt;
    cov_next     = cov;
    case (state_reg)
      IDLE: begin
        s_ready_next = 1'b0;
        busy_next    = 1'b0;
        if (start) begin
          state_next   = RUN;
          op_next      = op;
          idle_next    = '0;
          cov_next     = '0;
          err_next     = '0;
          timeout_next = 1'b0;
          pass_next    = 1'b0;
          s_ready_next = 1'b1;
          busy_next    = 1'b1;
        end
      end
      RUN: begin
        // Completion requires an acceptance, which also clears the idle count,
        // so it always takes precedence over the timeout path.
        if (accept) begin
          err_next  = err_inc;
          cov_next  = cov | cov_hit;
          idle_next = '0;
          if ((cov | cov_hit) == 4'b1111) begin
            state_next   = DONE;
            s_ready_next = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            pass_next    = (err_inc == '0);
          end
        end else begin
          idle_next = idle_reg + 1'b1;
          if (idle_next == IDLE_LIMIT) begin
            state_next   = DONE;
            s_ready_next = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            timeout_next = 1'b1;
            pass_next    = 1'b0;
          end
        end
      end
      DONE: begin
        state_next   = IDLE;
        s_ready_next = 1'b0;
        busy_next    = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        s_ready_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      idle_reg  <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      cov       <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      idle_reg  <= idle_next;
      s_ready   <= s_ready_next;
      busy      <= busy_next;
      done      <= done_next;
      pass      <= pass_next;
      timeout   <= timeout_next;
      err_cnt   <= err_next;
      cov       <= cov_next;
    end
  end

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  logic [2:0] fail_vec_next;
  logic       fail_vld_next;

  // Only the first mismatch of a session is kept; later ones leave it frozen.
  always_comb begin
    fail_vec_next = fail_vec;
    fail_vld_next = fail_vld[0];
    if ((state_reg == IDLE) && start) begin
      fail_vec_next = '0;
      fail_vld_next = 1'b0;
    end else if (mismatch && !fail_vld[0]) begin
      fail_vec_next = {s_a, s_b, s_y};
      fail_vld_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec <= '0;
      fail_vld <= '0;
    end else begin
      fail_vec <= fail_vec_next;
      fail_vld <= fail_vld_next;
    end
  end
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: session-level reference model plus directed scenarios.
// Two instances share stimulus: default ERR_W and ERR_W=2 for saturation.
module tb_gate_checker;

  localparam int TO = 64;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic       s_valid, s_a, s_b, s_y;

  logic       s_ready, busy, done, pass, timeout;
  logic [7:0] err_cnt;
  logic [3:0] cov;
  logic       s_ready2, busy2, done2, pass2, timeout2;
  logic [1:0] err_cnt2;
  logic [3:0] cov2;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  logic [2:0] fail_vec, fail_vec2;
  logic [0:0] fail_vld, fail_vld2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gate_checker #(.ERR_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s_valid(s_valid),
    .s_a(s_a), .s_b(s_b), .s_y(s_y), .s_ready(s_ready), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov), .timeout(timeout)
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec), .fail_vld(fail_vld)
`endif
  );

  gate_checker #(.ERR_W(2), .TIMEOUT_CYC(TO)) dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .s_valid(s_valid),
    .s_a(s_a), .s_b(s_b), .s_y(s_y), .s_ready(s_ready2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err_cnt2), .cov(cov2), .timeout(timeout2)
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec2), .fail_vld(fail_vld2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gate functions as truth tables indexed by {a,b}.
  function automatic logic ref_y(input logic [1:0] f, input logic a, input logic b);
    logic [3:0] tt;
    case (f)
      2'b00:   tt = 4'b1000;
      2'b01:   tt = 4'b1110;
      2'b10:   tt = 4'b0110;
      default: tt = 4'b0111;
    endcase
    return tt[{a, b}];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Session model: unsaturated mismatch total, seen-pair set, quiet-cycle count.
  logic       m_busy, m_done, m_pass, m_to;
  logic [1:0] m_op;
  logic [3:0] m_cov;
  int         m_mism, m_quiet;
  logic [2:0] m_fvec;
  logic       m_fvld;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_pass <= 0; m_to <= 0; m_op <= 0;
      m_cov <= 0; m_mism <= 0; m_quiet <= 0; m_fvec <= 0; m_fvld <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1; m_op <= op; m_cov <= 0; m_mism <= 0; m_to <= 0;
        m_pass <= 0; m_quiet <= 0; m_fvec <= 0; m_fvld <= 0;
      end
    end else if (s_valid) begin
      m_cov   <= m_cov | (4'b0001 << {s_a, s_b});
      m_mism  <= m_mism + ((ref_y(m_op, s_a, s_b) !== s_y) ? 1 : 0);
      m_quiet <= 0;
      if ((ref_y(m_op, s_a, s_b) !== s_y) && !m_fvld) begin
        m_fvec <= {s_a, s_b, s_y};
        m_fvld <= 1;
      end
      if ((m_cov | (4'b0001 << {s_a, s_b})) == 4'hF) begin
        m_busy <= 0;
        m_done <= 1;
        m_pass <= (m_mism == 0) && (ref_y(m_op, s_a, s_b) === s_y);
      end
    end else begin
      m_quiet <= m_quiet + 1;
      if (m_quiet + 1 >= TO) begin
        m_busy <= 0; m_done <= 1; m_to <= 1; m_pass <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready", s_ready, m_busy);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("timeout", timeout, m_to);
    chk("cov", cov, m_cov);
    chk("err_cnt", err_cnt, sat(m_mism, 255));
    chk("err_cnt_w2", err_cnt2, sat(m_mism, 3));
    chk("busy_w2", busy2, m_busy);
    chk("cov_w2", cov2, m_cov);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    chk("fail_vec", fail_vec, m_fvec);
    chk("fail_vld", fail_vld, m_fvld);
`endif
  end

  task automatic do_start(input logic [1:0] f);
    int n;
    n = 0;
    s_valid = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_idle", {busy, done}, 0);
    start = 1; op = f;
    @(negedge clk);
    start = 0;
  endtask

  task automatic smp(input logic a, input logic b, input logic y);
    s_valid = 1; s_a = a; s_b = b; s_y = y;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int n);
    s_valid = 0;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", done, 1);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; op = 0; s_valid = 0; s_a = 0; s_b = 0; s_y = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_cov", cov, 0);
    rst = 0;
    @(negedge clk);

    // AND, all correct: done one cycle after the 4th acceptance
    do_start(2'b00);
    smp(0, 0, 0); smp(0, 1, 0); smp(1, 0, 0); smp(1, 1, 1);
    chk("and_done_latency", done, 1);
    chk("and_pass", pass, 1);
    chk("and_err", err_cnt, 0);
    chk("and_cov", cov, 4'hF);
    $display("txn and_all_ok: pass=%0d err=%0d cov=%b", pass, err_cnt, cov);

    // XOR, last sample wrong
    do_start(2'b10);
    smp(0, 0, 0); smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 1);
    wait_done(8, n);
    chk("xor_err", err_cnt, 1);
    chk("xor_pass", pass, 0);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    chk("xor_fail_vec", fail_vec, 3'b111);
    chk("xor_fail_vld", fail_vld, 1);
`endif
    $display("txn xor_one_err: pass=%0d err=%0d", pass, err_cnt);

    // OR, two samples then silence: timeout after 64 idle cycles
    do_start(2'b01);
    smp(0, 0, 0); smp(0, 1, 1);
    wait_done(TO + 8, n);
    chk("to_idle_cycles", n, TO);
    chk("to_flag", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_cov", cov, 4'b0011);
    $display("txn or_timeout: cycles=%0d timeout=%0d cov=%b", n, timeout, cov);

    // NAND, 5 wrong then 3 correct: saturation on the narrow instance
    do_start(2'b11);
    repeat (5) smp(0, 0, 0);
    smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 0);
    wait_done(8, n);
    chk("nand_err_w2", err_cnt2, 3);
    chk("nand_err_w8", err_cnt, 5);
    chk("nand_pass_w2", pass2, 0);
    $display("txn nand_saturate: err_w2=%0d err_w8=%0d", err_cnt2, err_cnt);

    // First mismatch capture stays frozen across a second mismatch
    do_start(2'b00);
    smp(0, 1, 1); smp(1, 1, 0); smp(0, 0, 0); smp(1, 0, 0);
    wait_done(8, n);
    chk("frz_err", err_cnt, 2);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    chk("frz_fail_vec", fail_vec, 3'b011);
    chk("frz_fail_vld", fail_vld, 1);
`endif
    $display("txn first_capture: err=%0d", err_cnt);

    // Asynchronous reset mid-session
    do_start(2'b00);
    smp(1, 1, 0); smp(0, 0, 0);
    s_valid = 0;
    chk("pre_rst_err", err_cnt, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", s_ready, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_cov", cov, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    do_start(2'b00);
    chk("clean_err", err_cnt, 0);
    smp(0, 0, 0); smp(0, 1, 0); smp(1, 0, 0); smp(1, 1, 1);
    wait_done(8, n);
    chk("clean_pass", pass, 1);
    $display("txn async_reset: clean session pass=%0d", pass);

    // start held high: op must not be re-latched mid-session
    n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1; op = 2'b10;
    @(negedge clk);
    op = 2'b00;
    smp(0, 0, 0); smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 0);
    wait_done(8, n);
    chk("hold_pass", pass, 1);
    chk("hold_err", err_cnt, 0);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    start = 0;
    smp(0, 0, 0); smp(0, 1, 0); smp(1, 0, 0); smp(1, 1, 1);
    wait_done(8, n);
    chk("hold_new_op_pass", pass, 1);
    $display("txn start_held: pass=%0d", pass);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
